// File: rtl/alu_mdu_control.sv
// EX-stage ALU decoder with an iterative multiply/divide unit, HI/LO registers,
// result-source select and a pipeline stall for dependent MD instructions.
//
// state | meaning
// IDLE  | no mul/div in flight; accepts a new MD op
// MUL   | shift-add, one multiplier bit per cycle
// DIV   | restoring shift-subtract, one quotient bit per cycle
// FIX   | sign-correct and write hi/lo
module alu_mdu_control #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       operation,
    output logic [1:0]       res_sel,
    output logic             stall,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2a;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic             md_op, mf_op, md_signed, md_is_div;
    logic             accept, last_iter;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] div_idx;

    logic [WIDTH-1:0]   op_a, op_b;
    logic               neg_a, neg_b, md_div, div_zero;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   abs_rs, abs_rt;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff, rem_next;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, rs_orig;

    // ALU operation and MD/mf classification
    always_comb begin
        operation = 4'h2;
        res_sel   = 2'b00;
        md_op     = 1'b0;
        mf_op     = 1'b0;
        md_signed = 1'b0;
        md_is_div = 1'b0;
        if (alu_op[0]) begin
            operation = 4'h6;
        end else if (alu_op == 2'b10) begin
            case (funct)
                F_ADD, F_ADDU: operation = 4'h2;
                F_SUB, F_SUBU: operation = 4'h6;
                F_AND:         operation = 4'h0;
                F_OR:          operation = 4'h1;
                F_NOR:         operation = 4'hc;
                F_SLT:         operation = 4'h7;
                default:       operation = 4'h2;
            endcase
            case (funct)
                F_MULT, F_MULTU, F_DIV, F_DIVU: md_op = 1'b1;
                F_MFHI: begin
                    mf_op   = 1'b1;
                    res_sel = 2'b01;
                end
                F_MFLO: begin
                    mf_op   = 1'b1;
                    res_sel = 2'b10;
                end
                default: ;
            endcase
            md_signed = (funct == F_MULT) || (funct == F_DIV);
            md_is_div = (funct == F_DIV) || (funct == F_DIVU);
        end
    end

    assign stall     = valid_in & (md_op | mf_op) & md_busy;
    assign accept    = (state == S_IDLE) & valid_in & md_op & ~stall;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = md_is_div ? S_DIV : S_MUL;
            S_MUL:  if (last_iter) state_nxt = S_FIX;
            S_DIV:  if (last_iter) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        md_busy = (state != S_IDLE);
    end

    assign abs_rs = (md_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign abs_rt = (md_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    // Multiplier bits consumed LSB first; product bits shift down into acc low half
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (op_b[cnt[IDX_W-1:0]] ? {1'b0, op_a} : '0);

    // Dividend is indexed MSB first so op_a survives for the divide-by-zero result
    assign div_idx   = IDX_W'(WIDTH - 1) - cnt[IDX_W-1:0];
    assign div_shift = {acc[2*WIDTH-1:WIDTH], op_a[div_idx]};
    assign div_ok    = (div_shift >= {1'b0, op_b});
    assign div_diff  = div_shift[WIDTH-1:0] - op_b;
    assign rem_next  = div_ok ? div_diff : div_shift[WIDTH-1:0];

    assign prod_fix = (neg_a ^ neg_b) ? -acc : acc;
    assign quo_fix  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign rs_orig  = neg_a ? -op_a : op_a;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a     <= '0;
            op_b     <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            md_div   <= 1'b0;
            div_zero <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            md_done  <= 1'b0;
        end else begin
            md_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_a     <= abs_rs;
                        op_b     <= abs_rt;
                        neg_a    <= md_signed & rs_val[WIDTH-1];
                        neg_b    <= md_signed & rt_val[WIDTH-1];
                        md_div   <= md_is_div;
                        div_zero <= (rt_val == '0);
                        acc      <= '0;
                        cnt      <= '0;
                    end
                end
                S_MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                end
                S_DIV: begin
                    acc <= {rem_next, acc[WIDTH-2:0], div_ok};
                    cnt <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    md_done <= 1'b1;
                    if (!md_div) begin
                        {hi, lo} <= prod_fix;
                    end else if (div_zero) begin
                        hi <= rs_orig;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu_control.sv
// Directed bench for alu_mdu_control: decode sweep, mul/div results via a
// scoreboard queue, stall length, back-to-back issue and mid-op reset.
module tb_alu_mdu_control;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [1:0]    alu_op;
    logic [5:0]    funct;
    logic [W-1:0]  rs_val, rt_val;
    logic [3:0]    operation;
    logic [1:0]    res_sel;
    logic          stall, md_busy, md_done;
    logic [W-1:0]  hi, lo;

    int n_checks = 0;
    int n_fails  = 0;
    logic [63:0] sb_q[$];

    alu_mdu_control #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .alu_op(alu_op),
        .funct(funct), .rs_val(rs_val), .rt_val(rt_val), .operation(operation),
        .res_sel(res_sel), .stall(stall), .md_busy(md_busy), .md_done(md_done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_op(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'h2;
        if (op[0]) return 4'h6;
        case (f)
            6'h20, 6'h21: return 4'h2;
            6'h22, 6'h23: return 4'h6;
            6'h24: return 4'h0;
            6'h25: return 4'h1;
            6'h27: return 4'hc;
            6'h2a: return 4'h7;
            default: return 4'h2;
        endcase
    endfunction

    function automatic logic [1:0] exp_sel(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b10 && f == 6'h10) return 2'b01;
        if (op == 2'b10 && f == 6'h12) return 2'b10;
        return 2'b00;
    endfunction

    // Reference {hi, lo} from native SV arithmetic
    function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint p;
        sa = a;
        sb = b;
        case (f)
            6'h18: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            6'h19: return {32'b0, a} * {32'b0, b};
            6'h1a: begin
                if (b == 0) return {a, 32'hffff_ffff};
                if (a == 32'h8000_0000 && b == 32'hffff_ffff) return {32'h0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 0) return {a, 32'hffff_ffff};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic start_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        valid_in = 1'b1;
        alu_op   = 2'b10;
        funct    = f;
        rs_val   = a;
        rt_val   = b;
        sb_q.push_back(md_model(f, a, b));
    endtask

    // Called before the accept edge; returns at the negedge where md_done is high
    task automatic wait_done(input string tag);
        int busy = 0;
        bit seen = 0;
        logic [63:0] e;
        @(negedge clk);
        valid_in = 1'b0;
        alu_op   = 2'b00;
        funct    = 6'h00;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (md_done) seen = 1;
            else begin
                if (md_busy) busy++;
                @(negedge clk);
            end
        end
        check({tag, " done seen"}, 64'(seen), 64'd1);
        check({tag, " busy cycles"}, 64'(busy), 64'd33);
        if (seen && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, " hi"}, 64'(hi), 64'(e[63:32]));
            check({tag, " lo"}, 64'(lo), 64'(e[31:0]));
        end
    endtask

    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start_md(f, a, b);
        wait_done(tag);
        @(negedge clk);
        check({tag, " done single pulse"}, 64'(md_done), 64'd0);
    endtask

    initial begin
        int stall_cyc;
        int done_cnt;
        logic [63:0] e;
        logic [5:0] fsel;
        logic [31:0] ra, rb;

        reset    = 1'b1;
        valid_in = 1'b0;
        alu_op   = 2'b00;
        funct    = 6'h00;
        rs_val   = '0;
        rt_val   = '0;
        #1;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(md_busy), 64'd0);
        check("reset done", 64'(md_done), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Decode sweep with bubbles so nothing is accepted
        for (int op = 0; op < 4; op++) begin
            for (int f = 0; f < 64; f++) begin
                alu_op = 2'(op);
                funct  = 6'(f);
                #1;
                check($sformatf("decode op%0d f%02h operation", op, f), 64'(operation), 64'(exp_op(2'(op), 6'(f))));
                check($sformatf("decode op%0d f%02h res_sel", op, f), 64'(res_sel), 64'(exp_sel(2'(op), 6'(f))));
            end
        end
        alu_op = 2'b10;
        funct  = 6'h18;
        @(posedge clk);
        #1;
        check("bubble md funct no accept", 64'(md_busy), 64'd0);
        check("bubble no stall", 64'(stall), 64'd0);

        run_md("mult -3*7", 6'h18, 32'hffff_fffd, 32'd7);
        run_md("divu 100/7", 6'h1b, 32'd100, 32'd7);
        run_md("div -7/2", 6'h1a, 32'hffff_fff9, 32'd2);
        run_md("div min/-1", 6'h1a, 32'h8000_0000, 32'hffff_ffff);
        run_md("div 5/0", 6'h1a, 32'd5, 32'd0);
        run_md("multu big", 6'h19, 32'hffff_ffff, 32'hffff_fffe);

        for (int i = 0; i < 6; i++) begin
            fsel = 6'h18 + 6'($urandom_range(0, 3));
            ra   = $urandom;
            rb   = $urandom;
            if (fsel[1] && rb == 0) rb = 32'd1;
            run_md($sformatf("random%0d f%02h", i, fsel), fsel, ra, rb);
        end

        // mult followed immediately by a dependent mflo
        @(negedge clk);
        start_md(6'h18, 32'hffff_fc18, 32'd12345);
        @(negedge clk);
        funct = 6'h12;
        #1;
        stall_cyc = 0;
        for (int i = 0; i < 100 && stall; i++) begin
            stall_cyc++;
            @(negedge clk);
            #1;
        end
        check("mflo stall cycles", 64'(stall_cyc), 64'd33);
        check("mflo release done", 64'(md_done), 64'd1);
        check("mflo res_sel", 64'(res_sel), 64'd2);
        e = sb_q.pop_front();
        check("mflo lo", 64'(lo), 64'(e[31:0]));
        check("mflo hi", 64'(hi), 64'(e[63:32]));

        // Back-to-back issue in the md_done cycle
        start_md(6'h1b, 32'd1000, 32'd33);
        #1;
        check("back-to-back no stall", 64'(stall), 64'd0);
        wait_done("back-to-back divu");
        @(negedge clk);

        // Reset ten cycles into a divide, with a dependent mfhi stalled
        @(negedge clk);
        start_md(6'h1a, 32'hffff_ffce, 32'd3);
        @(negedge clk);
        funct = 6'h20;
        #1;
        check("alu op during busy no stall", 64'(stall), 64'd0);
        funct = 6'h10;
        repeat (9) @(negedge clk);
        #1;
        check("pre-reset stall", 64'(stall), 64'd1);
        check("pre-reset busy", 64'(md_busy), 64'd1);
        reset = 1'b1;
        #1;
        check("mid-op reset hi", 64'(hi), 64'd0);
        check("mid-op reset lo", 64'(lo), 64'd0);
        check("mid-op reset busy", 64'(md_busy), 64'd0);
        check("mid-op reset stall", 64'(stall), 64'd0);
        sb_q.delete();
        valid_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md_done) done_cnt++;
        end
        check("no done after reset", 64'(done_cnt), 64'd0);
        run_md("mult after reset", 6'h18, 32'd123456, 32'hffff_ff85);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
